// File: rtl/proc_wait_timer_array.sv
// proc_wait_timer_array
//   Multi-channel process wait-timer. Each channel loads a wait time from
//   the relative, external or registered event-reference source, counts it
//   down and pulses ch_expire once it runs out. An aggregated clock-gate
//   enable (any channel busy, or forced) qualifies sampling of ckg_ind.
//
// Optional feature macro: PROC_WAIT_RELOAD_EN
//   defined   : ch_reload[j] re-arms channel j with its last loaded value at
//               expiry (periodic mode); a last-load register per channel.
//   undefined : one-shot only, ch_reload ignored.
//
// Ports
//   clk, rst_n     : single clock, synchronous active-low reset
//   cmd_valid/ready: command handshake (ready combinational from state)
//   cmd_type       : 0=CANCEL 1=REL 2=EXT 3=EVENT, others illegal
//   cmd_ch         : target channel
//   proc_rel_time, proc_ext_time, event_proc : per-channel times, ch j at [j*TW +: TW]
//   ch_reload      : per-channel auto-reload request
//   ckg_force      : force clock-gate enable
//   ckg_ind        : clock-gate indication to sample
//   ch_busy        : channel counting (WAIT)
//   ch_expire      : one-cycle expiry pulse
//   cmd_err        : one-cycle pulse after an illegal command is accepted
//   ckg_en         : |ch_busy | ckg_force
//   ckg_ind_1d     : ckg_ind sampled on edges where ckg_en=1
module proc_wait_timer_array #(
  parameter int CH  = 2,
  parameter int TW  = 8,
  parameter int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_type,
  input  logic [CHW-1:0]   cmd_ch,
  input  logic [CH*TW-1:0] proc_rel_time,
  input  logic [CH*TW-1:0] proc_ext_time,
  input  logic [CH*TW-1:0] event_proc,
  input  logic [CH-1:0]    ch_reload,
  input  logic             ckg_force,
  input  logic             ckg_ind,
  output logic [CH-1:0]    ch_busy,
  output logic [CH-1:0]    ch_expire,
  output logic             cmd_err,
  output logic             ckg_en,
  output logic             ckg_ind_1d
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  localparam logic [4:0]   T_CANCEL = 5'd0;
  localparam logic [4:0]   T_REL    = 5'd1;
  localparam logic [4:0]   T_EXT    = 5'd2;
  localparam logic [4:0]   T_EVENT  = 5'd3;
  localparam logic [CHW:0] CH_L     = CH[CHW:0];

  state_e           state_q [CH];
  state_e           state_d [CH];
  logic [TW-1:0]    cnt_q   [CH];
  logic [TW-1:0]    cnt_d   [CH];
  logic [TW-1:0]    load_val[CH];
  logic [CH-1:0]    expire_q, expire_d;
  logic [CH-1:0]    hit, busy;
  logic [CH*TW-1:0] reftime_q;
  logic             cmd_err_q, ckg_ind_1d_q;
  logic             is_cancel, is_load, ch_oob, cmd_bad, sel_busy, accept;

`ifdef PROC_WAIT_RELOAD_EN
  logic [TW-1:0]    last_q [CH];
  logic [TW-1:0]    last_d [CH];
`else
  logic             unused_reload;
  assign unused_reload = ^ch_reload;
`endif

  // Command decode and handshake
  always_comb begin
    is_cancel = (cmd_type == T_CANCEL);
    is_load   = cmd_type inside {T_REL, T_EXT, T_EVENT};
    ch_oob    = ({1'b0, cmd_ch} >= CH_L);
    cmd_bad   = ch_oob | ~(is_cancel | is_load);
    sel_busy  = 1'b0;
    for (int unsigned j = 0; j < CH; j++) begin
      if (cmd_ch == CHW'(j)) sel_busy = busy[j];
    end
    cmd_ready = (is_cancel | cmd_bad) ? 1'b1 : ~sel_busy;
    accept    = cmd_valid & cmd_ready;
  end

  // Next-state logic per channel
  always_comb begin
    for (int unsigned j = 0; j < CH; j++) begin
      hit[j]      = accept & ~cmd_bad & (cmd_ch == CHW'(j));
      load_val[j] = proc_rel_time[j*TW +: TW];
      if (cmd_type == T_EXT)        load_val[j] = proc_ext_time[j*TW +: TW];
      else if (cmd_type == T_EVENT) load_val[j] = reftime_q[j*TW +: TW];

      state_d[j]  = state_q[j];
      cnt_d[j]    = cnt_q[j];
      expire_d[j] = 1'b0;
`ifdef PROC_WAIT_RELOAD_EN
      last_d[j]   = last_q[j];
`endif
      if (hit[j] && is_cancel) begin
        // Cancel beats the WAIT->DONE step, so no expire pulse.
        state_d[j] = S_IDLE;
        cnt_d[j]   = '0;
      end else if (hit[j] && is_load) begin
        cnt_d[j] = load_val[j];
`ifdef PROC_WAIT_RELOAD_EN
        last_d[j] = load_val[j];
`endif
        if (load_val[j] == '0) begin
          state_d[j]  = S_DONE;
          expire_d[j] = 1'b1;
        end else begin
          state_d[j] = S_WAIT;
        end
      end else begin
        unique case (state_q[j])
          S_WAIT: begin
            // cnt==0 in WAIT only arises from a reload of 0; it expires too.
            if (cnt_q[j] <= TW'(1)) begin
              expire_d[j] = 1'b1;
              state_d[j]  = S_DONE;
              cnt_d[j]    = '0;
`ifdef PROC_WAIT_RELOAD_EN
              if (ch_reload[j]) begin
                state_d[j] = S_WAIT;
                cnt_d[j]   = last_q[j];
              end
`endif
            end else begin
              cnt_d[j] = cnt_q[j] - TW'(1);
            end
          end
          S_DONE:  state_d[j] = S_IDLE;
          default: ;
        endcase
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < CH; j++) begin
        state_q[j] <= S_IDLE;
        cnt_q[j]   <= '0;
`ifdef PROC_WAIT_RELOAD_EN
        last_q[j]  <= '0;
`endif
      end
      expire_q     <= '0;
      reftime_q    <= '0;
      cmd_err_q    <= 1'b0;
      ckg_ind_1d_q <= 1'b0;
    end else begin
      for (int unsigned j = 0; j < CH; j++) begin
        state_q[j] <= state_d[j];
        cnt_q[j]   <= cnt_d[j];
`ifdef PROC_WAIT_RELOAD_EN
        last_q[j]  <= last_d[j];
`endif
      end
      expire_q  <= expire_d;
      reftime_q <= event_proc;
      cmd_err_q <= accept & cmd_bad;
      if (ckg_en) ckg_ind_1d_q <= ckg_ind;
    end
  end

  // Outputs
  always_comb begin
    busy = '0;
    for (int unsigned j = 0; j < CH; j++) begin
      busy[j] = (state_q[j] == S_WAIT);
    end
    ch_busy    = busy;
    ch_expire  = expire_q;
    cmd_err    = cmd_err_q;
    ckg_en     = (|busy) | ckg_force;
    ckg_ind_1d = ckg_ind_1d_q;
  end

endmodule

// File: tb/tb_proc_wait_timer_array.sv
module tb_proc_wait_timer_array;
  localparam int CH = 2;
  localparam int TW = 8;

  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_ready;
  logic [4:0]  cmd_type;
  logic [0:0]  cmd_ch;
  logic [15:0] proc_rel_time, proc_ext_time, event_proc;
  logic [1:0]  ch_reload, ch_busy, ch_expire;
  logic        ckg_force, ckg_ind, cmd_err, ckg_en, ckg_ind_1d;

  always #5 clk = ~clk;

  proc_wait_timer_array #(.CH(CH), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_ch(cmd_ch), .proc_rel_time(proc_rel_time),
    .proc_ext_time(proc_ext_time), .event_proc(event_proc), .ch_reload(ch_reload),
    .ckg_force(ckg_force), .ckg_ind(ckg_ind), .ch_busy(ch_busy),
    .ch_expire(ch_expire), .cmd_err(cmd_err), .ckg_en(ckg_en), .ckg_ind_1d(ckg_ind_1d)
  );

  typedef struct {
    logic        rst, vld;
    logic [4:0]  typ;
    logic        ch;
    logic [15:0] rel, ext, ev;
    logic        frc, ind, pre, e_rdy, e_ckg;
    logic [1:0]  e_busy, e_exp;
    logic        e_err, e_ind1d;
  } vec_t;

  typedef struct {
    logic [1:0] busy, expire;
    logic       err, ind1d, ckg;
  } post_t;

  vec_t  tv[$];
  post_t sb[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, vld, input logic [4:0] typ, input logic ch,
                              input logic [15:0] rel, ext, ev, input logic frc, ind, pre,
                              e_rdy, e_ckg, input logic [1:0] e_busy, e_exp,
                              input logic e_err, e_ind1d);
    vec_t v;
    v.rst = rst; v.vld = vld; v.typ = typ; v.ch = ch; v.rel = rel; v.ext = ext; v.ev = ev;
    v.frc = frc; v.ind = ind; v.pre = pre; v.e_rdy = e_rdy; v.e_ckg = e_ckg;
    v.e_busy = e_busy; v.e_exp = e_exp; v.e_err = e_err; v.e_ind1d = e_ind1d;
    return v;
  endfunction

  task automatic drive(input logic rst, vld, input logic [4:0] typ, input logic ch,
                       input logic [15:0] rel, ext, ev, input logic [1:0] rld,
                       input logic frc, ind);
    rst_n = rst; cmd_valid = vld; cmd_type = typ; cmd_ch = ch;
    proc_rel_time = rel; proc_ext_time = ext; event_proc = ev;
    ch_reload = rld; ckg_force = frc; ckg_ind = ind;
  endtask

  task automatic post_check(input string tag);
    post_t p;
    p = sb.pop_front();
    chk({tag, ".busy"},   32'(ch_busy),    32'(p.busy));
    chk({tag, ".expire"}, 32'(ch_expire),  32'(p.expire));
    chk({tag, ".err"},    32'(cmd_err),    32'(p.err));
    chk({tag, ".ind1d"},  32'(ckg_ind_1d), 32'(p.ind1d));
    chk({tag, ".ckg_en"}, 32'(ckg_en),     32'(p.ckg));
  endtask

  initial begin
    post_t p;
    logic  e_busy0, e_exp0;
    //        rst vld typ ch rel      ext      ev       frc ind pre rdy ckg busy   exp    err ind1d
    tv.push_back(mk(0,1,1,0,16'h0005,16'h0000,16'h0000,1,1, 0,0,0, 2'b00,2'b00,0,0)); // v0 reset w/ traffic
    tv.push_back(mk(0,1,1,0,16'h0005,16'h0000,16'h0000,1,1, 1,1,1, 2'b00,2'b00,0,0)); // v1 reset, ckg_en=force
    tv.push_back(mk(1,1,1,0,16'h0005,16'h0000,16'h0000,0,1, 1,1,0, 2'b01,2'b00,0,0)); // v2 REL 5 ch0, ind held
    tv.push_back(mk(1,1,2,0,16'h0005,16'h0009,16'h0000,0,1, 1,0,1, 2'b01,2'b00,0,1)); // v3 EXT to busy ch0 refused
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,1, 2'b01,2'b00,0,0)); // v4
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,1, 1,1,1, 2'b01,2'b00,0,1)); // v5
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,1, 1,1,1, 2'b01,2'b00,0,1)); // v6
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,1, 2'b00,2'b01,0,0)); // v7 expire 5 after accept
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0300,0,1, 1,1,0, 2'b00,2'b00,0,0)); // v8 idle: ind1d holds; ev ch1=3
    tv.push_back(mk(1,1,3,1,16'h0000,16'h0000,16'h0900,0,1, 1,1,0, 2'b10,2'b00,0,0)); // v9 EVENT ch1 uses 3
    tv.push_back(mk(1,1,7,0,16'h0000,16'h0000,16'h0900,0,0, 1,1,1, 2'b10,2'b00,1,0)); // v10 illegal type
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,1, 2'b10,2'b00,0,0)); // v11
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,1, 2'b00,2'b10,0,0)); // v12 ch1 expires
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,0, 2'b00,2'b00,0,0)); // v13
    tv.push_back(mk(1,1,1,0,16'h0001,16'h0000,16'h0000,0,0, 1,1,0, 2'b01,2'b00,0,0)); // v14 REL 1 ch0
    tv.push_back(mk(1,1,1,1,16'h0001,16'h0000,16'h0000,0,0, 1,1,1, 2'b00,2'b11,0,0)); // v15 REL 0 ch1
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,0, 2'b00,2'b00,0,0)); // v16
    tv.push_back(mk(1,1,1,0,16'h0002,16'h0000,16'h0000,0,0, 1,1,0, 2'b01,2'b00,0,0)); // v17 REL 2 ch0
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,1, 2'b01,2'b00,0,0)); // v18
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,1, 2'b00,2'b01,0,0)); // v19 DONE
    tv.push_back(mk(1,1,1,0,16'h0003,16'h0000,16'h0000,0,0, 1,1,0, 2'b01,2'b00,0,0)); // v20 load in DONE wins
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,1, 2'b01,2'b00,0,0)); // v21
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,1, 2'b01,2'b00,0,0)); // v22 cnt==1
    tv.push_back(mk(1,1,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,1, 2'b00,2'b00,0,0)); // v23 CANCEL at cnt==1
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,0, 2'b00,2'b00,0,0)); // v24 no late expire
    tv.push_back(mk(1,1,1,1,16'h0400,16'h0000,16'h0000,0,0, 1,1,0, 2'b10,2'b00,0,0)); // v25 REL 4 ch1
    tv.push_back(mk(1,1,2,1,16'h0000,16'h0100,16'h0000,0,0, 1,0,1, 2'b10,2'b00,0,0)); // v26 EXT refused
    tv.push_back(mk(0,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,1, 2'b00,2'b00,0,0)); // v27 reset mid-count
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,0, 2'b00,2'b00,0,0)); // v28 no pulse
    tv.push_back(mk(1,1,2,0,16'h0000,16'h0002,16'h0000,0,0, 1,1,0, 2'b01,2'b00,0,0)); // v29 EXT 2 ch0
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,1, 2'b01,2'b00,0,0)); // v30
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,1, 2'b00,2'b01,0,0)); // v31
    tv.push_back(mk(1,0,0,0,16'h0000,16'h0000,16'h0000,0,0, 1,1,0, 2'b00,2'b00,0,0)); // v32

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].vld, tv[i].typ, tv[i].ch, tv[i].rel, tv[i].ext, tv[i].ev,
            2'b00, tv[i].frc, tv[i].ind);
      p.busy = tv[i].e_busy; p.expire = tv[i].e_exp; p.err = tv[i].e_err;
      p.ind1d = tv[i].e_ind1d; p.ckg = (|tv[i].e_busy) | tv[i].frc;
      sb.push_back(p);
      #1;
      if (tv[i].pre) begin
        chk($sformatf("v%0d.ready", i),  32'(cmd_ready), 32'(tv[i].e_rdy));
        chk($sformatf("v%0d.ckg_pre", i), 32'(ckg_en),   32'(tv[i].e_ckg));
      end
      @(posedge clk); #1;
      post_check($sformatf("v%0d", i));
    end

    // Reload sequence: REL 4 on ch0 with ch_reload[0]=1, then observe 10 edges.
    for (int k = 0; k < 11; k++) begin
      if (k == 0) drive(1, 1, 5'd1, 1'b0, 16'h0004, 16'h0000, 16'h0000, 2'b01, 0, 0);
      else        drive(1, 0, 5'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'b01, 0, 0);
`ifdef PROC_WAIT_RELOAD_EN
      e_busy0 = 1'b1;
      e_exp0  = (k > 0) && (k % 4 == 0);
`else
      e_busy0 = (k <= 3);
      e_exp0  = (k == 4);
`endif
      p.busy = {1'b0, e_busy0}; p.expire = {1'b0, e_exp0}; p.err = 1'b0;
      p.ind1d = 1'b0; p.ckg = e_busy0;
      sb.push_back(p);
      @(posedge clk); #1;
      post_check($sformatf("reload.k%0d", k));
    end

    // Cancel stops any periodic channel.
    drive(1, 1, 5'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'b01, 0, 0);
    p.busy = 2'b00; p.expire = 2'b00; p.err = 1'b0; p.ind1d = 1'b0; p.ckg = 1'b0;
    sb.push_back(p);
    @(posedge clk); #1;
    post_check("reload.cancel");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
